// File: rtl/reg_file_2w2r_if.sv
// Bus bundle for the two-write/two-read register file.
// Master drives indices and write data; slave returns reads and the conflict flag.
interface reg_file_2w2r_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] R_reg1;
  logic [ADDR_W-1:0] R_reg2;
  logic [DATA_W-1:0] R_data1;
  logic [DATA_W-1:0] R_data2;
  logic [ADDR_W-1:0] W_reg0;
  logic [DATA_W-1:0] W_data0;
  logic              RegWrite0;
  logic [ADDR_W-1:0] W_reg1;
  logic [DATA_W-1:0] W_data1;
  logic              RegWrite1;
  logic              W_conflict;

  modport master (
    output R_reg1, R_reg2,
    output W_reg0, W_data0, RegWrite0,
    output W_reg1, W_data1, RegWrite1,
    input  R_data1, R_data2, W_conflict
  );

  modport slave (
    input  R_reg1, R_reg2,
    input  W_reg0, W_data0, RegWrite0,
    input  W_reg1, W_data1, RegWrite1,
    output R_data1, R_data2, W_conflict
  );
endinterface

// File: rtl/reg_file_2w2r.sv
// Two-write, two-read register file; port 1 wins same-index writes.
// Optional macro REGFILE_BYPASS_EN forwards pending write data to reads.
module reg_file_2w2r #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic            CLK,
  input logic            nRST,
  reg_file_2w2r_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_conflict;
  logic              w_we0;
  logic              w_we1;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  assign w_we0 = bus.RegWrite0 && !(ZR && bus.W_reg0 == '0);
  assign w_we1 = bus.RegWrite1 && !(ZR && bus.W_reg1 == '0);

  // Port 1 is applied last so it overrides port 0 on the same index.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_conflict <= 1'b0;
    end else begin
      if (w_we0) begin
        r_mem[bus.W_reg0] <= bus.W_data0;
      end
      if (w_we1) begin
        r_mem[bus.W_reg1] <= bus.W_data1;
      end
      r_conflict <= bus.RegWrite0 && bus.RegWrite1 &&
                    (bus.W_reg0 == bus.W_reg1);
    end
  end

  function automatic logic [DATA_W-1:0] rd_sel(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] v;
    v = r_mem[a];
`ifdef REGFILE_BYPASS_EN
    if (bus.RegWrite1 && bus.W_reg1 == a) begin
      v = bus.W_data1;
    end else if (bus.RegWrite0 && bus.W_reg0 == a) begin
      v = bus.W_data0;
    end
`endif
    if (!nRST || (ZR && a == '0)) begin
      v = '0;
    end
    return v;
  endfunction

  always_comb begin
    w_rd1 = rd_sel(bus.R_reg1);
    w_rd2 = rd_sel(bus.R_reg2);
  end

  assign bus.R_data1    = w_rd1;
  assign bus.R_data2    = w_rd2;
  assign bus.W_conflict = r_conflict;

endmodule

// File: tb/tb_reg_file_2w2r.sv
// Directed self-checking bench for reg_file_2w2r.
// Expected values follow the bypass macro when it is defined.
module tb_reg_file_2w2r;

  localparam int DW = 32;
  localparam int AW = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic CLK;
  logic nRST;
  int   checks;
  int   errors;

  reg_file_2w2r_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  reg_file_2w2r #(
    .DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.RegWrite0 = 1'b0;
    bus.RegWrite1 = 1'b0;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.W_reg0 = a; bus.W_data0 = d; bus.RegWrite0 = 1'b1;
  endtask

  task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.W_reg1 = a; bus.W_data1 = d; bus.RegWrite1 = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nRST = 1'b0;
    bus.R_reg1 = '0; bus.R_reg2 = '0;
    bus.W_reg0 = '0; bus.W_data0 = '0;
    bus.W_reg1 = '0; bus.W_data1 = '0;
    idle();
    #2;
    chk("rst_rd1", bus.R_data1, 32'h0);
    chk("rst_conf", {31'b0, bus.W_conflict}, 32'h0);

    // writes while reset is held are ignored
    wr0(5'd12, 32'hCAFE0000);
    tick();
    idle();
    #2 nRST = 1'b1;
    bus.R_reg2 = 5'd12;
    #1 chk("rst_nowrite", bus.R_data2, 32'h0);

    // single write
    wr0(5'd5, 32'hDEADBEEF);
    tick();
    idle();
    bus.R_reg1 = 5'd5;
    #1 chk("single", bus.R_data1, 32'hDEADBEEF);

    // dual write, distinct indices
    wr0(5'd3, 32'h11);
    wr1(5'd7, 32'h22);
    tick();
    idle();
    bus.R_reg1 = 5'd3;
    bus.R_reg2 = 5'd7;
    #1;
    chk("dual_p0", bus.R_data1, 32'h11);
    chk("dual_p1", bus.R_data2, 32'h22);
    chk("dual_conf", {31'b0, bus.W_conflict}, 32'h0);

    // same-index conflict
    wr0(5'd9, 32'hAAAA);
    wr1(5'd9, 32'h5555);
    tick();
    idle();
    bus.R_reg1 = 5'd9;
    #1;
    chk("conf_data", bus.R_data1, 32'h5555);
    chk("conf_flag", {31'b0, bus.W_conflict}, 32'h1);
    tick();
    chk("conf_clear", {31'b0, bus.W_conflict}, 32'h0);

    // hardwired zero register, both ports targeting it
    bus.R_reg1 = 5'd0;
    wr0(5'd0, 32'hFFFFFFFF);
    wr1(5'd0, 32'hFFFFFFFF);
    #1 chk("zero_pre", bus.R_data1, 32'h0);
    tick();
    idle();
    #1;
    chk("zero_post", bus.R_data1, 32'h0);
    chk("zero_conf", {31'b0, bus.W_conflict}, 32'h1);

    // bypass of a pending write
    wr0(5'd4, 32'h1111);
    tick();
    idle();
    bus.R_reg2 = 5'd4;
    wr0(5'd4, 32'h1234);
    #1 chk("byp_pre", bus.R_data2, BYP ? 32'h1234 : 32'h1111);
    tick();
    idle();
    #1 chk("byp_post", bus.R_data2, 32'h1234);

    // bypass priority: port 1 ahead of port 0
    bus.R_reg1 = 5'd6;
    wr0(5'd6, 32'h77);
    wr1(5'd6, 32'h66);
    #1 chk("prio_pre", bus.R_data1, BYP ? 32'h66 : 32'h0);
    tick();
    idle();
    #1 chk("prio_post", bus.R_data1, 32'h66);

    // both read ports on one index
    bus.R_reg1 = 5'd5;
    bus.R_reg2 = 5'd5;
    #1;
    chk("same_rd1", bus.R_data1, 32'hDEADBEEF);
    chk("same_rd2", bus.R_data2, 32'hDEADBEEF);

    // asynchronous reset mid-cycle with a raised conflict flag
    wr0(5'd9, 32'h1);
    wr1(5'd9, 32'h2);
    tick();
    idle();
    chk("pre_rst_conf", {31'b0, bus.W_conflict}, 32'h1);
    #1 nRST = 1'b0;
    #1;
    chk("arst_rd1", bus.R_data1, 32'h0);
    chk("arst_rd2", bus.R_data2, 32'h0);
    chk("arst_conf", {31'b0, bus.W_conflict}, 32'h0);
    #1 nRST = 1'b1;
    bus.R_reg1 = 5'd3;
    bus.R_reg2 = 5'd9;
    #1;
    chk("arst_clr3", bus.R_data1, 32'h0);
    chk("arst_clr9", bus.R_data2, 32'h0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
